// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: EX forwarding selects, load-use,
// branch/jump/interrupt flushes and memory-busy freeze. HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] IF_ID_Rs,
   input  logic [REG_AW-1:0] IF_ID_Rt,
   input  logic [REG_AW-1:0] ID_EX_Wr,
   input  logic              ID_EX_RegWr,
   input  logic              ID_EX_MemRd,
   input  logic [REG_AW-1:0] EX_MEM_Wr,
   input  logic              EX_MEM_RegWr,
   input  logic              EX_Branch_EN,
   input  logic              ID_Jump,
   input  logic              mem_busy,
   input  logic              irq,
   input  logic              irq_en,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              pc_stall,
   output logic              if_id_stall,
   output logic              id_ex_stall,
   output logic              ex_mem_stall,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              irq_take,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_IRQ_WAIT = 2'd2,
      ST_IRQ_TAKE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_irq_pend;
   logic [1:0]  r_fwd_a;
   logic [1:0]  r_fwd_b;
   logic [1:0]  w_fwd_a;
   logic [1:0]  w_fwd_b;
   logic        w_lu;
   logic        w_run_act;

   // EX result beats MEM result; register 0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] ex_wr,
                                          input logic              ex_regwr,
                                          input logic [REG_AW-1:0] mem_wr,
                                          input logic              mem_regwr);
      if (ex_regwr && (ex_wr != '0) && (ex_wr == src))
         return 2'b10;
      else if (mem_regwr && (mem_wr != '0) && (mem_wr == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign w_fwd_a = fwd_sel(IF_ID_Rs, ID_EX_Wr, ID_EX_RegWr, EX_MEM_Wr, EX_MEM_RegWr);
   assign w_fwd_b = fwd_sel(IF_ID_Rt, ID_EX_Wr, ID_EX_RegWr, EX_MEM_Wr, EX_MEM_RegWr);
   assign w_lu    = ID_EX_MemRd && (ID_EX_Wr != '0) &&
                    ((ID_EX_Wr == IF_ID_Rs) || (ID_EX_Wr == IF_ID_Rt));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_irq_pend <= 1'b0;
      end else begin
         r_state <= w_next;
         if (irq_take)
            r_irq_pend <= 1'b0;
         else if (irq && irq_en)
            r_irq_pend <= 1'b1;
      end
   end

   // Forward selects follow the ID/EX register: hold on stall, clear on bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (id_ex_flush) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (!id_ex_stall) begin
         r_fwd_a <= w_fwd_a;
         r_fwd_b <= w_fwd_b;
      end
   end

   assign ForwardA = r_fwd_a;
   assign ForwardB = r_fwd_b;

   always_comb begin
      w_next       = r_state;
      w_run_act    = 1'b0;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      irq_take     = 1'b0;

      case (r_state)
         ST_RUN, ST_IRQ_WAIT: begin
            if (mem_busy) begin
               w_next = ST_MEM_WAIT;
            end else begin
               w_run_act = 1'b1;
               if (EX_Branch_EN || !r_irq_pend)
                  w_next = ST_RUN;
               else if (ID_Jump || w_lu)
                  w_next = ST_IRQ_WAIT;
               else
                  w_next = ST_IRQ_TAKE;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_busy) begin
               w_run_act = 1'b1;
               w_next    = ST_RUN;
            end
         end
         ST_IRQ_TAKE: begin
            irq_take    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_next      = ST_RUN;
         end
         default: w_next = ST_RUN;
      endcase

      // Freeze whenever memory is busy in any waiting/running state
      if (mem_busy && (r_state != ST_IRQ_TAKE)) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
      end

      if (w_run_act) begin
         if (EX_Branch_EN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (ID_Jump) begin
            if_id_flush = 1'b1;
         end else if (w_lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end

      if (if_id_flush) if_id_stall = 1'b0;
      if (id_ex_flush) id_ex_stall = 1'b0;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (if_id_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_AW-1:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Wr, EX_MEM_Wr;
   logic              ID_EX_RegWr, ID_EX_MemRd, EX_MEM_RegWr;
   logic              EX_Branch_EN, ID_Jump, mem_busy, irq, irq_en;
   logic [1:0]        ForwardA, ForwardB;
   logic              pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic              if_id_flush, id_ex_flush, irq_take;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;
   logic [6:0]        ctl;
   logic [3:0]        fwd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
      .ID_EX_Wr(ID_EX_Wr), .ID_EX_RegWr(ID_EX_RegWr), .ID_EX_MemRd(ID_EX_MemRd),
      .EX_MEM_Wr(EX_MEM_Wr), .EX_MEM_RegWr(EX_MEM_RegWr),
      .EX_Branch_EN(EX_Branch_EN), .ID_Jump(ID_Jump), .mem_busy(mem_busy),
      .irq(irq), .irq_en(irq_en),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .irq_take(irq_take), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, irq_take}
   assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, irq_take};
   assign fwd = {ForwardA, ForwardB};

   task automatic clear_inputs();
      IF_ID_Rs = '0; IF_ID_Rt = '0; ID_EX_Wr = '0; EX_MEM_Wr = '0;
      ID_EX_RegWr = 1'b0; ID_EX_MemRd = 1'b0; EX_MEM_RegWr = 1'b0;
      EX_Branch_EN = 1'b0; ID_Jump = 1'b0; mem_busy = 1'b0; irq = 1'b0; irq_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      settle();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b want 0000", fwd); end
      n_tests++;
      if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000000", ctl); end
      n_tests++;
      if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
         n_fail++; $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_forward_ex();
      clear_inputs();
      ID_EX_Wr = 5'd8; ID_EX_RegWr = 1'b1; IF_ID_Rs = 5'd8;
      settle();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL fwd_ex_latency: got %b want 0000", fwd); end
      tick();
      n_tests++;
      if (fwd !== 4'b1000) begin n_fail++; $display("FAIL fwd_ex: got %b want 1000", fwd); end
      ID_EX_Wr = 5'd0; IF_ID_Rs = 5'd0;
      tick();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL fwd_ex_r0: got %b want 0000", fwd); end
   endtask

   task automatic test_forward_mem();
      clear_inputs();
      EX_MEM_Wr = 5'd9; EX_MEM_RegWr = 1'b1; IF_ID_Rt = 5'd9;
      tick();
      n_tests++;
      if (fwd !== 4'b0001) begin n_fail++; $display("FAIL fwd_mem: got %b want 0001", fwd); end
      EX_MEM_Wr = 5'd0; IF_ID_Rt = 5'd0;
      tick();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL fwd_mem_r0: got %b want 0000", fwd); end
      ID_EX_Wr = 5'd5; ID_EX_RegWr = 1'b1; EX_MEM_Wr = 5'd5; EX_MEM_RegWr = 1'b1;
      IF_ID_Rs = 5'd5; IF_ID_Rt = 5'd5;
      tick();
      n_tests++;
      if (fwd !== 4'b1010) begin n_fail++; $display("FAIL fwd_prio: got %b want 1010", fwd); end
      ID_EX_RegWr = 1'b0;
      tick();
      n_tests++;
      if (fwd !== 4'b0101) begin n_fail++; $display("FAIL fwd_mem_only: got %b want 0101", fwd); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      ID_EX_MemRd = 1'b1; ID_EX_RegWr = 1'b1; ID_EX_Wr = 5'd8; IF_ID_Rt = 5'd8;
      settle();
      n_tests++;
      if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lu_ctl: got %b want 1100010", ctl); end
      tick();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_fwd: got %b want 0000", fwd); end
      ID_EX_MemRd = 1'b0; ID_EX_RegWr = 1'b0; ID_EX_Wr = 5'd0;
      EX_MEM_Wr = 5'd8; EX_MEM_RegWr = 1'b1;
      settle();
      n_tests++;
      if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0000000", ctl); end
      tick();
      n_tests++;
      if (fwd !== 4'b0001) begin n_fail++; $display("FAIL lu_after_fwd: got %b want 0001", fwd); end
   endtask

   task automatic test_branch_jump();
      clear_inputs();
      ID_EX_MemRd = 1'b1; ID_EX_RegWr = 1'b1; ID_EX_Wr = 5'd8; IF_ID_Rs = 5'd8;
      EX_Branch_EN = 1'b1;
      settle();
      n_tests++;
      if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL branch_lu: got %b want 0000110", ctl); end
      tick();
      clear_inputs();
      ID_Jump = 1'b1;
      settle();
      n_tests++;
      if (ctl !== 7'b0000100) begin n_fail++; $display("FAIL jump: got %b want 0000100", ctl); end
      tick();
   endtask

   task automatic test_mem_busy();
      clear_inputs();
      ID_EX_Wr = 5'd8; ID_EX_RegWr = 1'b1; IF_ID_Rs = 5'd8;
      tick();
      n_tests++;
      if (fwd !== 4'b1000) begin n_fail++; $display("FAIL mb_setup_fwd: got %b want 1000", fwd); end
      ID_EX_RegWr = 1'b0; IF_ID_Rs = 5'd3;
      for (int i = 0; i < 3; i++) begin
         mem_busy = 1'b1;
         EX_Branch_EN = (i == 0);
         settle();
         n_tests++;
         if (ctl !== 7'b1111000) begin
            n_fail++; $display("FAIL mb_stall_%0d: got %b want 1111000", i, ctl);
         end
         tick();
         n_tests++;
         if (fwd !== 4'b1000) begin
            n_fail++; $display("FAIL mb_fwd_hold_%0d: got %b want 1000", i, fwd);
         end
      end
      mem_busy = 1'b0; EX_Branch_EN = 1'b0;
      settle();
      n_tests++;
      if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL mb_release: got %b want 0000000", ctl); end
      tick();
      n_tests++;
      if (fwd !== 4'b0000) begin n_fail++; $display("FAIL mb_after_fwd: got %b want 0000", fwd); end
   endtask

   task automatic test_irq_jump();
      logic [6:0] exp_seq [6];
      exp_seq = '{7'b0000000, 7'b0000100, 7'b0000000, 7'b0000111, 7'b0000000, 7'b0000000};
      clear_inputs();
      irq_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         irq     = (c == 0);
         ID_Jump = (c == 1);
         settle();
         n_tests++;
         if (ctl !== exp_seq[c]) begin
            n_fail++; $display("FAIL irq_jump_c%0d: got %b want %b", c, ctl, exp_seq[c]);
         end
         tick();
      end
   endtask

   task automatic test_irq_direct();
      logic [6:0] exp_seq [4];
      exp_seq = '{7'b0000000, 7'b0000000, 7'b0000111, 7'b0000000};
      clear_inputs();
      irq_en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         irq = (c == 0);
         settle();
         n_tests++;
         if (ctl !== exp_seq[c]) begin
            n_fail++; $display("FAIL irq_direct_c%0d: got %b want %b", c, ctl, exp_seq[c]);
         end
         tick();
      end
      irq = 1'b1; irq_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_tests++;
         if (irq_take !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked_c%0d: got %b want 0", c, irq_take);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      irq = 1'b1; irq_en = 1'b1; mem_busy = 1'b1;
      tick();
      irq = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; mem_busy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_tests++;
         if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL reset_mid_c%0d: got %b want 0000000", c, ctl);
         end
         tick();
      end
   endtask

   task automatic test_counters();
`ifdef HAZARD_PERF_CNT_EN
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_busy = 1'b1;
      tick();
      tick();
      mem_busy = 1'b0; EX_Branch_EN = 1'b1;
      tick();
      clear_inputs();
      tick();
      n_tests++;
      if ((stall_cnt !== 32'd2) || (flush_cnt !== 32'd1)) begin
         n_fail++; $display("FAIL perf_cnt: got stall=%0d flush=%0d want 2 1", stall_cnt, flush_cnt);
      end
`else
      n_tests++;
      if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
         n_fail++; $display("FAIL perf_cnt_tied: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_forward_ex();
      test_forward_mem();
      test_load_use();
      test_branch_jump();
      test_mem_busy();
      test_irq_jump();
      test_irq_direct();
      test_reset_mid();
      test_counters();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
